// File: rtl/lp_tree_deserializer.sv
// Serial-to-parallel receiver for the lp_tree serializer link.
// Hunts for an in-band sync word, then emits each data word with a one-cycle valid pulse.
module lp_tree_deserializer #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SERIAL_IN,
    input  logic             RESYNC,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             PAR_VALID,
    output logic             LOCKED,
    output logic [15:0]      WORD_CNT
);

    localparam int BW = $clog2(WIDTH);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             valid_q, valid_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] cand;

    assign cand = {sr_q[WIDTH-2:0], SERIAL_IN};

    always_comb begin
        state_d = state_q;
        sr_d    = cand;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (RESYNC) begin
            // A word completing this cycle is dropped.
            state_d = ST_HUNT;
            sr_d    = '0;
            bcnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_HUNT: begin
                    if (cand == SYNC_WORD) begin
                        state_d = ST_LOCK;
                        bcnt_d  = '0;
                    end
                end
                ST_LOCK: begin
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d = '0;
                        // Sync words seen in lock are idle fill, not data.
                        if (cand != SYNC_WORD) begin
                            par_d   = cand;
                            valid_d = 1'b1;
                            cnt_d   = cnt_q + 16'd1;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_HUNT;
            sr_q    <= '0;
            bcnt_q  <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PAR_OUT   = par_q;
    assign PAR_VALID = valid_q;
    assign LOCKED    = (state_q == ST_LOCK);
    assign WORD_CNT  = cnt_q;

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Self-checking bench for lp_tree_deserializer.
// Directed scenarios plus randomized streams checked against a bit-queue reference model.
module tb_lp_tree_deserializer;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        SERIAL_IN = 1'b0;
    logic        RESYNC = 1'b0;
    logic [7:0]  PAR_OUT;
    logic        PAR_VALID;
    logic        LOCKED;
    logic [15:0] WORD_CNT;

    int n_checks = 0;
    int n_fail = 0;

    lp_tree_deserializer #(.WIDTH(8), .SYNC_WORD(SYNC)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .SERIAL_IN(SERIAL_IN),
        .RESYNC(RESYNC),
        .PAR_OUT(PAR_OUT),
        .PAR_VALID(PAR_VALID),
        .LOCKED(LOCKED),
        .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a sliding window for hunting, a bit queue for words.
    logic [7:0]  m_win;
    logic        m_locked;
    logic        m_q[$];
    logic [7:0]  m_par;
    logic        m_valid;
    logic [15:0] m_cnt;
    int          m_pulses;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic rs, input logic b);
        logic [7:0] w;
        m_valid = 1'b0;
        if (!rst) begin
            m_win = '0; m_locked = 1'b0; m_q.delete();
            m_par = '0; m_cnt = '0;
        end else if (rs) begin
            m_win = '0; m_locked = 1'b0; m_q.delete();
        end else begin
            m_win = {m_win[6:0], b};
            if (!m_locked) begin
                if (m_win == SYNC) begin
                    m_locked = 1'b1;
                    m_q.delete();
                end
            end else begin
                m_q.push_back(b);
                if (m_q.size() == 8) begin
                    w = '0;
                    foreach (m_q[i]) w = {w[6:0], m_q[i]};
                    m_q.delete();
                    if (w != SYNC) begin
                        m_par = w;
                        m_valid = 1'b1;
                        m_cnt = m_cnt + 16'd1;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic rs, input logic b);
        RESET = rst;
        RESYNC = rs;
        SERIAL_IN = b;
        @(posedge CLK);
        model_step(rst, rs, b);
        #1;
        if (m_valid) m_pulses++;
        check("valid", 32'(PAR_VALID), 32'(m_valid));
        check("locked", 32'(LOCKED), 32'(m_locked));
        check("word_cnt", 32'(WORD_CNT), 32'(m_cnt));
        check("par_out", 32'(PAR_OUT), 32'(m_par));
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) cycle(1'b1, 1'b0, w[i]);
    endtask

    initial begin
        int p0;
        logic [7:0] w;
        logic [7:0] c0;
        m_pulses = 0;

        // Reset with random serial data
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'($urandom));
        check("rst_locked", 32'(LOCKED), 32'd0);
        check("rst_cnt", 32'(WORD_CNT), 32'd0);
        check("rst_par", 32'(PAR_OUT), 32'd0);
        p0 = m_pulses;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
        check("zeros_no_lock", 32'(LOCKED), 32'd0);
        check("zeros_no_pulse", 32'(m_pulses - p0), 32'd0);

        // Lock and data
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        send_word(SYNC);
        check("lock_latency", 32'(LOCKED), 32'd1);
        send_word(8'hAF);
        check("w_af", 32'(PAR_OUT), 32'hAF);
        send_word(8'h3C);
        check("w_3c", 32'(PAR_OUT), 32'h3C);
        send_word(8'h00);
        check("w_00", 32'(PAR_OUT), 32'h00);
        check("cnt3", 32'(WORD_CNT), 32'd3);

        // Idle discard
        p0 = m_pulses;
        send_word(SYNC);
        send_word(SYNC);
        send_word(8'h12);
        check("idle_pulses", 32'(m_pulses - p0), 32'd1);
        check("idle_par", 32'(PAR_OUT), 32'h12);
        check("idle_cnt", 32'(WORD_CNT), 32'd4);

        // Resync colliding with word completion
        p0 = m_pulses;
        for (int i = 7; i >= 1; i--) cycle(1'b1, 1'b0, w_77(i));
        cycle(1'b1, 1'b1, 1'b1);
        check("resync_unlock", 32'(LOCKED), 32'd0);
        check("resync_nopulse", 32'(m_pulses - p0), 32'd0);
        send_word(SYNC);
        check("relock", 32'(LOCKED), 32'd1);
        send_word(8'h5A);
        check("relock_par", 32'(PAR_OUT), 32'h5A);

        // Mid-word reset
        p0 = m_pulses;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'($urandom));
        cycle(1'b0, 1'b0, 1'b1);
        check("mid_rst_locked", 32'(LOCKED), 32'd0);
        check("mid_rst_cnt", 32'(WORD_CNT), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        check("mid_rst_nopulse", 32'(m_pulses - p0), 32'd0);

        // Randomized streams with idles and occasional resync
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 6)); k++)
                cycle(1'b1, 1'b0, 1'($urandom));
            send_word(SYNC);
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
                w = 8'($urandom);
                if ($urandom_range(0, 5) == 0) w = SYNC;
                if ($urandom_range(0, 9) == 0) begin
                    c0 = 8'($urandom_range(0, 7));
                    for (int i = 7; i >= 0; i--)
                        cycle(1'b1, 32'(i) == 32'(c0), w[i]);
                end else begin
                    send_word(w);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    function automatic logic w_77(input int i);
        logic [7:0] v;
        v = 8'h77;
        return v[i];
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
